// File: rtl/core_cmd_arbiter.sv
// Round-robin arbiter sharing one command/response port between NREQ
// requesters, one transaction in flight, with a response watchdog.
module core_cmd_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NREQ-1:0]    i_req_valid,
    input  logic [NREQ-1:0]    i_req_write,
    input  logic [NREQ*DW-1:0] i_req_data,
    input  logic [NREQ*AW-1:0] i_req_addr,
    output logic [NREQ-1:0]    o_req_busy,
    output logic [NREQ-1:0]    o_req_rsp_stb,
    output logic [DW-1:0]      o_req_rsp_word,
    output logic               o_req_rsp_err,
    output logic               o_cmd_valid,
    output logic               o_cmd_write,
    output logic [DW-1:0]      o_cmd_data,
    output logic [AW-1:0]      o_cmd_addr,
    input  logic               i_cmd_busy,
    input  logic               i_rsp_stb,
    input  logic [DW-1:0]      i_rsp_word
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] LP_TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   r_grant;
    logic [TW-1:0]   r_timer;
    logic [GW-1:0]   w_pick;
    logic            w_found;
    int              w_dist;
    int              w_best;
    logic            w_wr;
    logic [DW-1:0]   w_data;
    logic [AW-1:0]   w_addr;
    logic            w_expire;
    logic [NREQ-1:0] w_onehot;

    assign w_expire = (r_timer == LP_TLAST);
    assign w_onehot = NREQ'(1) << r_grant;

    // Round-robin search: nearest valid requester after the last one served.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_dist = k - int'(r_last) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (i_req_valid[k] && (w_dist < w_best)) begin
                w_found = 1'b1;
                w_pick  = GW'(k);
                w_best  = w_dist;
            end
        end
    end

    // Mux the command fields of the picked requester.
    always_comb begin
        w_wr   = 1'b0;
        w_data = '0;
        w_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick == GW'(k)) begin
                w_wr   = i_req_write[k];
                w_data = i_req_data[k*DW +: DW];
                w_addr = i_req_addr[k*AW +: AW];
            end
        end
    end

    // Only the picked requester sees busy low, and only while idle.
    always_comb begin
        o_req_busy = '1;
        if ((r_state == S_IDLE) && w_found && !i_reset) begin
            o_req_busy[w_pick] = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a response in the expiry cycle still counts as a response.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (!i_cmd_busy) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_rsp_stb || w_expire) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: command capture, watchdog timer and response routing.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last         <= GW'(NREQ - 1);
            r_grant        <= '0;
            r_timer        <= '0;
            o_req_rsp_stb  <= '0;
            o_req_rsp_word <= '0;
            o_req_rsp_err  <= 1'b0;
            o_cmd_valid    <= 1'b0;
            o_cmd_write    <= 1'b0;
            o_cmd_data     <= '0;
            o_cmd_addr     <= '0;
        end else begin
            o_req_rsp_stb <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_pick;
                        o_cmd_valid <= 1'b1;
                        o_cmd_write <= w_wr;
                        o_cmd_data  <= w_data;
                        o_cmd_addr  <= w_addr;
                    end
                end
                S_ISSUE: begin
                    if (!i_cmd_busy) begin
                        o_cmd_valid <= 1'b0;
                        r_timer     <= '0;
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (i_rsp_stb) begin
                        o_req_rsp_stb  <= w_onehot;
                        o_req_rsp_word <= i_rsp_word;
                        o_req_rsp_err  <= 1'b0;
                        r_last         <= r_grant;
                    end else if (w_expire) begin
                        o_req_rsp_stb  <= w_onehot;
                        o_req_rsp_word <= '0;
                        o_req_rsp_err  <= 1'b1;
                        r_last         <= r_grant;
                    end
                end
                default: begin
                    o_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
